// File: rtl/ntt_pkg.sv
// Shared NTT constants, mode enum and modular-reduction helpers.
// Q = Q_K*2^Q_M+1; K-reduction maps C to Q_K*C mod Q.
package ntt_pkg;

  localparam int Q          = 3329;
  localparam int Q_K        = 13;
  localparam int Q_M        = 8;
  localparam int DATA_WIDTH = 12;

  // signed reduction intermediate width
  localparam int RED_W = 2*DATA_WIDTH+1;

  localparam int RED_STEPS_DEF = 2;

  typedef enum logic {
    MM_MONT  = 1'b0,
    MM_PLAIN = 1'b1
  } mo_mode_e;

  // R^2 mod Q with R = 2^(steps*Q_M)
  function automatic int mont_r2(input int steps);
    int r;
    r = 1;
    for (int i = 0; i < steps*Q_M; i++)
      r = (r*2) % Q;
    return (r*r) % Q;
  endfunction

  localparam int MONT_R2 = mont_r2(RED_STEPS_DEF);

  // One K-red step: Q_K*c0 - c1 == -C*2^-Q_M (mod Q).
  // Steps come in pairs so the sign cancels.
  function automatic logic signed [RED_W-1:0] kred(
    input logic signed [RED_W-1:0] c
  );
    logic signed [RED_W-1:0] k, lo, hi;
    k  = RED_W'(Q_K);
    lo = {{(RED_W-Q_M){1'b0}}, c[Q_M-1:0]};
    hi = c >>> Q_M;
    return k*lo - hi;
  endfunction

  // input lies in (-Q, 2Q) after two steps on in-range operands
  function automatic logic [DATA_WIDTH-1:0] canon(
    input logic signed [RED_W-1:0] r
  );
    logic signed [RED_W-1:0] q, v;
    q = RED_W'(Q);
    v = r;
    if (v < 0)
      v = v + q;
    else if (v >= q)
      v = v - q;
    return v[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/mo_mul_array_pipe.sv
// One lane, one pass: z = x*y*R^-1 mod Q, canonical.
// Ports: clk, en (stall-all advance), x, y in; z out. No reset.
module mont_red_pipe
  import ntt_pkg::*;
#(
  parameter int MUL_STAGES = 1,
  parameter int RED_STEPS  = 2
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  output logic [DATA_WIDTH-1:0] z
);

  localparam int PW = 2*DATA_WIDTH;

  logic [PW-1:0]           prod [MUL_STAGES];
  logic signed [RED_W-1:0] red  [RED_STEPS];

  always_ff @(posedge clk) begin
    if (en) begin
      prod[0] <= PW'(x) * PW'(y);
      for (int i = 1; i < MUL_STAGES; i++)
        prod[i] <= prod[i-1];
      red[0] <= kred({1'b0, prod[MUL_STAGES-1]});
      for (int i = 1; i < RED_STEPS; i++)
        red[i] <= kred(red[i-1]);
      z <= canon(red[RED_STEPS-1]);
    end
  end

endmodule

// File: rtl/mo_mul_array.sv
// LANES-wide pipelined modular multiplier, valid/ready, stall-all.
// Ports: clk, rst, in_* (valid/ready/mode/tag/a/b), out_* (valid/ready/tag/data).
module mo_mul_array
  import ntt_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int TAG_W      = 8,
  parameter int MUL_STAGES = 1,
  parameter int RED_STEPS  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_mode,
  input  logic [TAG_W-1:0]            in_tag,
  input  logic [LANES*DATA_WIDTH-1:0] in_a,
  input  logic [LANES*DATA_WIDTH-1:0] in_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TAG_W-1:0]            out_tag,
  output logic [LANES*DATA_WIDTH-1:0] out_data
);

  localparam int D   = MUL_STAGES + RED_STEPS + 1;
  localparam int LAT = 2*D;
  localparam int DW  = DATA_WIDTH;

  localparam logic [DW-1:0] R2 = DW'(mont_r2(RED_STEPS));

  logic             adv;
  logic [LAT-1:0]   vld;
  mo_mode_e         mode [LAT];
  logic [TAG_W-1:0] tag  [LAT];

  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld[LAT-1];

  always_ff @(posedge clk) begin
    if (rst)
      vld <= '0;
    else if (adv)
      vld <= {vld[LAT-2:0], in_valid};
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      mode[0] <= mo_mode_e'(in_mode);
      tag[0]  <= in_tag;
      for (int i = 1; i < LAT; i++) begin
        mode[i] <= mode[i-1];
        tag[i]  <= tag[i-1];
      end
    end
  end

  // gated by valid so reset and bubbles present zeros
  assign out_tag = out_valid ? tag[LAT-1] : '0;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DW-1:0] p1, p2;
    logic [DW-1:0] bp [D];

    mont_red_pipe #(
      .MUL_STAGES (MUL_STAGES),
      .RED_STEPS  (RED_STEPS)
    ) u_p1 (
      .clk (clk),
      .en  (adv),
      .x   (in_a[g*DW +: DW]),
      .y   (in_b[g*DW +: DW]),
      .z   (p1)
    );

    // second pass lifts a*b*R^-1 back to a*b
    mont_red_pipe #(
      .MUL_STAGES (MUL_STAGES),
      .RED_STEPS  (RED_STEPS)
    ) u_p2 (
      .clk (clk),
      .en  (adv),
      .x   (p1),
      .y   (R2),
      .z   (p2)
    );

    always_ff @(posedge clk) begin
      if (adv) begin
        bp[0] <= p1;
        for (int i = 1; i < D; i++)
          bp[i] <= bp[i-1];
      end
    end

    assign out_data[g*DW +: DW] =
      !out_valid                 ? '0 :
      (mode[LAT-1] == MM_PLAIN)  ? p2 :
                                   bp[D-1];
  end

endmodule
